// File: rtl/serial_twos_comp.sv
// rtl/serial_twos_comp.sv - bit-serial two's-complement negator with one-hot timing sequencer
// Copies operand bits LSB-first until the first 1 has passed, then inverts the rest.
module serial_twos_comp #(
  parameter int N_BITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_BITS-1:0] B,
  output logic              busy,
  output logic [N_BITS:0]   T,
  output logic              serial_out,
  output logic [N_BITS-1:0] result,
  output logic              done,
  output logic              ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic [N_BITS-1:0] r_sr;
  logic [N_BITS-1:0] r_res_sr;
  logic              r_seen_one;
  logic              r_b_msb;
  logic [N_BITS:0]   r_t;
  logic              r_busy;
  logic              r_done;
  logic [N_BITS-1:0] r_result;
  logic              r_ovf;

  logic              w_serial;
  logic [N_BITS-1:0] w_res_next;

  // Gated by SHIFT so the bit reads 0 outside the serial window.
  assign w_serial   = (r_state == S_SHIFT) & (r_seen_one ? ~r_sr[0] : r_sr[0]);
  assign w_res_next = {w_serial, r_res_sr[N_BITS-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sr       <= '0;
      r_res_sr   <= '0;
      r_seen_one <= 1'b0;
      r_b_msb    <= 1'b0;
      r_t        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sr       <= B;
            r_b_msb    <= B[N_BITS-1];
            r_seen_one <= 1'b0;
            r_res_sr   <= '0;
            r_t        <= {{N_BITS{1'b0}}, 1'b1};
            r_busy     <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_seen_one <= r_seen_one | r_sr[0];
          r_sr       <= r_sr >> 1;
          r_res_sr   <= w_res_next;
          r_t        <= {r_t[N_BITS-1:0], 1'b0};
          if (r_t[N_BITS-1]) begin
            // Last bit: publish the finished word together with done.
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_result <= w_res_next;
            r_ovf    <= w_res_next[N_BITS-1] & r_b_msb;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_t     <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_t     <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign T          = r_t;
  assign serial_out = w_serial;
  assign result     = r_result;
  assign done       = r_done;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_serial_twos_comp.sv
// tb/tb_serial_twos_comp.sv - self-checking bench for serial_twos_comp
// Reference: result = -B mod 256, ovf = (B == 8'h80), serial bit k = result bit k.
module tb_serial_twos_comp;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] B;
  logic       busy;
  logic [8:0] T;
  logic       serial_out;
  logic [7:0] result;
  logic       done;
  logic       ovf;

  int tests;
  int fails;

  serial_twos_comp #(.N_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .B(B), .busy(busy), .T(T),
    .serial_out(serial_out), .result(result), .done(done), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model_neg(input logic [7:0] b);
    int v;
    v = (256 - int'(b)) % 256;
    return v[7:0];
  endfunction

  function automatic logic model_ovf(input logic [7:0] b);
    return b == 8'h80;
  endfunction

  // Runs one operation and records what the DUT showed in the 10 cycles after accept.
  task automatic do_op(input logic [7:0] b, output logic [9:0][8:0] t_log,
                       output logic [9:0] busy_log, output logic [7:0] ser,
                       output int done_cyc, output logic [7:0] res, output logic ov);
    B = b;
    start = 1'b1;
    step();
    start = 1'b0;
    B = 8'($urandom);
    done_cyc = -1;
    res = 8'hxx;
    ov = 1'bx;
    ser = '0;
    for (int c = 0; c < 10; c++) begin
      t_log[c] = T;
      busy_log[c] = busy;
      if (c < 8) ser[c] = serial_out;
      if (done && done_cyc < 0) done_cyc = c;
      if (c == 8) begin
        res = result;
        ov = ovf;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    B = 8'h00;
    step();
    step();
    tests++;
    if ({T, busy, done, ovf, result, serial_out} !== 21'd0) begin
      fails++;
      $display("FAIL reset: T=%h busy=%b done=%b ovf=%b result=%h ser=%b, required all 0",
               T, busy, done, ovf, result, serial_out);
    end
    rst_n = 1'b1;
    step();
    tests++;
    if (T !== 9'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: T=%h busy=%b, required 0/0", T, busy);
    end
  endtask

  task automatic check_op(input string name, input logic [7:0] b);
    logic [9:0][8:0] t_log;
    logic [9:0]      busy_log;
    logic [7:0]      ser;
    int              done_cyc;
    logic [7:0]      res;
    logic            ov;
    logic [7:0]      exp_r;
    logic [8:0]      exp_t;
    do_op(b, t_log, busy_log, ser, done_cyc, res, ov);
    exp_r = model_neg(b);
    for (int c = 0; c < 10; c++) begin
      exp_t = (c < 9) ? (9'd1 << c) : 9'd0;
      tests++;
      if (t_log[c] !== exp_t || busy_log[c] !== (c < 9)) begin
        fails++;
        $display("FAIL %s T_seq B=%h cycle %0d: T=%h busy=%b, required T=%h busy=%b",
                 name, b, c, t_log[c], busy_log[c], exp_t, (c < 9));
      end
    end
    tests++;
    if (done_cyc != 8) begin
      fails++;
      $display("FAIL %s done_cycle B=%h: got %0d, required 8", name, b, done_cyc);
    end
    tests++;
    if (ser !== exp_r) begin
      fails++;
      $display("FAIL %s serial B=%h: got %b (msb..lsb), required %b", name, b, ser, exp_r);
    end
    tests++;
    if (res !== exp_r || ov !== model_ovf(b)) begin
      fails++;
      $display("FAIL %s result B=%h: result=%h ovf=%b, required %h/%b",
               name, b, res, ov, exp_r, model_ovf(b));
    end
  endtask

  task automatic test_directed();
    check_op("dir05", 8'h05);
    check_op("dir06", 8'h06);
    check_op("dir00", 8'h00);
    check_op("dir80", 8'h80);
    check_op("dir01", 8'h01);
    tests++;
    if (result !== 8'hFF) begin
      fails++;
      $display("FAIL result_hold: result=%h, required FF", result);
    end
  endtask

  task automatic test_back_to_back();
    B = 8'h05;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    tests++;
    if (T !== 9'h008) begin
      fails++;
      $display("FAIL b2b_T3: T=%h, required 008", T);
    end
    B = 8'h33;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 4; c < 8; c++) step();
    tests++;
    if (done !== 1'b1 || T !== 9'h100 || result !== 8'hFB || ovf !== 1'b0) begin
      fails++;
      $display("FAIL b2b_ignore: done=%b T=%h result=%h ovf=%b, required 1/100/FB/0",
               done, T, result, ovf);
    end
    B = 8'h06;
    start = 1'b1;
    step();
    tests++;
    if (T !== 9'd0 || busy !== 1'b0 || result !== 8'hFB) begin
      fails++;
      $display("FAIL b2b_idle: T=%h busy=%b result=%h, required 000/0/FB", T, busy, result);
    end
    step();
    start = 1'b0;
    tests++;
    if (T !== 9'h001 || busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_reaccept: T=%h busy=%b, required 001/1", T, busy);
    end
    for (int c = 1; c < 9; c++) step();
    tests++;
    if (done !== 1'b1 || result !== 8'hFA) begin
      fails++;
      $display("FAIL b2b_second: done=%b result=%h, required 1/FA", done, result);
    end
    step();
    step();
  endtask

  task automatic test_mid_reset();
    int seen_done;
    B = 8'h55;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 4; c++) step();
    tests++;
    if (T !== 9'h010) begin
      fails++;
      $display("FAIL rst_T4: T=%h, required 010", T);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (T !== 9'd0 || busy !== 1'b0 || result !== 8'd0 || done !== 1'b0) begin
      fails++;
      $display("FAIL rst_async: T=%h busy=%b result=%h done=%b, required 0", T, busy, result, done);
    end
    step();
    rst_n = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) seen_done++;
      step();
    end
    tests++;
    if (seen_done != 0) begin
      fails++;
      $display("FAIL rst_no_done: %0d done pulses, required 0", seen_done);
    end
    check_op("rst7F", 8'h7F);
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int i = 0; i < 1000; i++) begin
      b = 8'($urandom);
      if (i == 0) b = 8'hFF;
      if (i == 1) b = 8'h7F;
      if (i == 2) b = 8'h81;
      check_op("rand", b);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
